decode_queue: RTL and testbench

- Parametrised successor to the single-entry decode stage.
- Decodes one RV32I-subset instruction per cycle under a valid/ready handshake into a DEPTH-entry queue of decoded micro-ops.
- Sits between fetch and rename/dispatch. Adds backpressure, flush, illegal-instruction detection, an extended ALU op set and an optional NOP-drop mode.

---
 rtl/decode_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_decode_queue.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// decode_queue: decodes one RV32I-subset word per cycle into a DEPTH-entry FIFO of micro-ops.
// Valid/ready on both sides; flush empties the queue and reset takes priority over flush.
module decode_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned DROP_NOP = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [XLEN-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [2:0]                 out_func3,
    output logic [XLEN-1:0]            out_imm,
    output logic                       out_LoadStore,
    output logic                       out_ALUSrc,
    output logic                       out_RegWrite,
    output logic                       out_BMS,
    output logic                       out_illegal,
    output logic [3:0]                 out_ALUControl,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [6:0] OpR     = 7'b0110011;
    localparam logic [6:0] OpImm   = 7'b0010011;
    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpLui   = 7'b0110111;
    localparam logic [6:0] OpNop   = 7'b0000000;

    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluXor = 4'b0011;
    localparam logic [3:0] AluAnd = 4'b0100;
    localparam logic [3:0] AluSll = 4'b0101;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b1000;
    localparam logic [3:0] AluSrl = 4'b1010;
    localparam logic [3:0] AluSra = 4'b1011;
    localparam logic [3:0] AluLui = 4'b1111;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      func3;
        logic [XLEN-1:0] imm;
        logic            ls;
        logic            alusrc;
        logic            regwrite;
        logic            bms;
        logic            illegal;
        logic [3:0]      aluctl;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    entry_t          w_dec;
    entry_t          w_head;
    logic            w_legal;
    logic            w_push;
    logic            w_enq;
    logic            w_pop;
    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_sh;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_imm_i  = XLEN'($signed(in_instr[31:20]));
    assign w_imm_s  = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign w_imm_u  = XLEN'($signed({in_instr[31:12], 12'b0}));
    assign w_imm_sh = XLEN'(in_instr[24:20]);

    always_comb begin
        w_legal      = 1'b1;
        w_dec        = '0;
        w_dec.pc     = in_pc;
        w_dec.opcode = w_opcode;
        w_dec.func3  = w_f3;
        w_dec.rd     = in_instr[11:7];
        w_dec.rs1    = in_instr[19:15];
        w_dec.rs2    = in_instr[24:20];
        case (w_opcode)
            OpR: begin
                w_dec.regwrite = 1'b1;
                case (w_f3)
                    3'b000:  w_dec.aluctl = w_f7[5] ? AluSub : AluAdd;
                    3'b001:  w_dec.aluctl = AluSll;
                    3'b010:  w_dec.aluctl = AluSlt;
                    3'b100:  w_dec.aluctl = AluXor;
                    3'b101:  w_dec.aluctl = w_f7[5] ? AluSra : AluSrl;
                    3'b110:  w_dec.aluctl = AluOr;
                    3'b111:  w_dec.aluctl = AluAnd;
                    default: w_legal = 1'b0;
                endcase
                if (w_f7 == 7'b0100000) begin
                    if (w_f3 != 3'b000 && w_f3 != 3'b101) w_legal = 1'b0;
                end else if (w_f7 != 7'b0000000) begin
                    w_legal = 1'b0;
                end
            end
            OpImm: begin
                w_dec.rs2      = '0;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.imm      = w_imm_i;
                case (w_f3)
                    3'b000: w_dec.aluctl = AluAdd;
                    3'b010: w_dec.aluctl = AluSlt;
                    3'b100: w_dec.aluctl = AluXor;
                    3'b110: w_dec.aluctl = AluOr;
                    3'b111: w_dec.aluctl = AluAnd;
                    3'b001: begin
                        w_dec.aluctl = AluSll;
                        w_dec.imm    = w_imm_sh;
                        if (w_f7 != 7'b0000000) w_legal = 1'b0;
                    end
                    3'b101: begin
                        w_dec.imm = w_imm_sh;
                        if (w_f7 == 7'b0000000)      w_dec.aluctl = AluSrl;
                        else if (w_f7 == 7'b0100000) w_dec.aluctl = AluSra;
                        else                         w_legal = 1'b0;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OpLoad: begin
                w_dec.rs2      = '0;
                w_dec.ls       = 1'b1;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluctl   = AluAdd;
                w_dec.imm      = w_imm_i;
                w_dec.bms      = (w_f3 == 3'b000);
                w_legal        = (w_f3 == 3'b000) || (w_f3 == 3'b010);
            end
            OpStore: begin
                w_dec.rd     = '0;
                w_dec.ls     = 1'b1;
                w_dec.alusrc = 1'b1;
                w_dec.aluctl = AluAdd;
                w_dec.imm    = w_imm_s;
                w_dec.bms    = (w_f3 == 3'b000);
                w_legal      = (w_f3 == 3'b000) || (w_f3 == 3'b010);
            end
            OpLui: begin
                w_dec.rs1      = '0;
                w_dec.rs2      = '0;
                w_dec.alusrc   = 1'b1;
                w_dec.regwrite = 1'b1;
                w_dec.aluctl   = AluLui;
                w_dec.imm      = w_imm_u;
            end
            OpNop: begin
                w_dec.rd    = '0;
                w_dec.rs1   = '0;
                w_dec.rs2   = '0;
                w_dec.func3 = '0;
            end
            default: w_legal = 1'b0;
        endcase
        if (w_dec.rd == 5'd0) w_dec.regwrite = 1'b0;
        // Illegal words keep only what a trap handler needs to report them.
        if (!w_legal) begin
            w_dec         = '0;
            w_dec.pc      = in_pc;
            w_dec.opcode  = w_opcode;
            w_dec.func3   = w_f3;
            w_dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_enq     = w_push && !((DROP_NOP != 0) && (w_opcode == OpNop));
    assign w_pop     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_count <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
        end else begin
            if (w_enq) r_wptr <= r_wptr + AW'(1);
            if (w_pop) r_rptr <= r_rptr + AW'(1);
            if (w_enq && !w_pop)      r_count <= r_count + CW'(1);
            else if (!w_enq && w_pop) r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq && !reset && !flush) r_mem[r_wptr] <= w_dec;
    end

    assign w_head         = out_valid ? r_mem[r_rptr] : '0;
    assign out_pc         = w_head.pc;
    assign out_opcode     = w_head.opcode;
    assign out_rd         = w_head.rd;
    assign out_rs1        = w_head.rs1;
    assign out_rs2        = w_head.rs2;
    assign out_func3      = w_head.func3;
    assign out_imm        = w_head.imm;
    assign out_LoadStore  = w_head.ls;
    assign out_ALUSrc     = w_head.alusrc;
    assign out_RegWrite   = w_head.regwrite;
    assign out_BMS        = w_head.bms;
    assign out_illegal    = w_head.illegal;
    assign out_ALUControl = w_head.aluctl;
    assign count          = r_count;

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed literal checks plus randomized traffic checked every cycle
// against a queue-based reference model built from the decode rules.
module tb_decode_queue;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DROP  = 1;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_func3;
    logic [31:0] out_imm;
    logic        out_LoadStore;
    logic        out_ALUSrc;
    logic        out_RegWrite;
    logic        out_BMS;
    logic        out_illegal;
    logic [3:0]  out_ALUControl;
    logic [2:0]  count;

    decode_queue #(
        .XLEN     (XLEN),
        .DEPTH    (DEPTH),
        .DROP_NOP (DROP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_rd         (out_rd),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_func3      (out_func3),
        .out_imm        (out_imm),
        .out_LoadStore  (out_LoadStore),
        .out_ALUSrc     (out_ALUSrc),
        .out_RegWrite   (out_RegWrite),
        .out_BMS        (out_BMS),
        .out_illegal    (out_illegal),
        .out_ALUControl (out_ALUControl),
        .count          (count)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
        logic        ls;
        logic        src;
        logic        rw;
        logic        bms;
        logic        ill;
        logic [3:0]  alu;
    } ent_t;

    ent_t mq[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode: legality first, then fields by instruction class.
    function automatic ent_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
        ent_t       e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] tab [8];
        bit         ok;
        bit         alt;
        op  = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        tab = '{4'd2, 4'd5, 4'd8, 4'd0, 4'd3, 4'd10, 4'd1, 4'd4};
        e = '0;
        e.pc = pc;
        e.op = op;
        e.f3 = f3;
        case (op)
            7'h33: ok = (f7 == 7'h00 && f3 != 3'd3) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            7'h13: ok = (f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7}) || (f3 == 3'd1 && f7 == 7'h00)
                        || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20));
            7'h03, 7'h23: ok = (f3 == 3'd0 || f3 == 3'd2);
            7'h37, 7'h00: ok = 1;
            default: ok = 0;
        endcase
        if (!ok) begin
            e.ill = 1'b1;
            return e;
        end
        if (op == 7'h00) begin
            e.f3 = 3'd0;
            return e;
        end
        alt = (f7 == 7'h20) && ((op == 7'h33 && f3 == 3'd0) || f3 == 3'd5);
        if (op == 7'h33 || op == 7'h13) e.alu = alt ? (f3 == 3'd0 ? 4'd6 : 4'd11) : tab[f3];
        else if (op == 7'h37)           e.alu = 4'd15;
        else                            e.alu = 4'd2;
        e.ls  = (op == 7'h03 || op == 7'h23);
        e.src = (op != 7'h33);
        e.bms = e.ls && (f3 == 3'd0);
        e.rd  = (op == 7'h23) ? 5'd0 : w[11:7];
        e.rs1 = (op == 7'h37) ? 5'd0 : w[19:15];
        e.rs2 = (op == 7'h33 || op == 7'h23) ? w[24:20] : 5'd0;
        e.rw  = (op != 7'h23) && (e.rd != 5'd0);
        if (op == 7'h33)                          e.imm = 32'd0;
        else if (op == 7'h37)                     e.imm = {w[31:12], 12'd0};
        else if (op == 7'h23)                     e.imm = {{20{w[31]}}, w[31:25], w[11:7]};
        else if (op == 7'h13 && f3[1:0] == 2'b01) e.imm = {27'd0, w[24:20]};
        else                                      e.imm = {{20{w[31]}}, w[31:20]};
        return e;
    endfunction

    function automatic void model_step();
        bit acc;
        bit pop;
        if (reset || flush) begin
            mq.delete();
            return;
        end
        acc = in_valid && (mq.size() < DEPTH);
        pop = out_ready && (mq.size() > 0);
        if (pop) void'(mq.pop_front());
        if (acc && !(DROP != 0 && in_instr[6:0] == 7'd0)) mq.push_back(ref_decode(in_instr, in_pc));
    endfunction

    always @(posedge clk) model_step();

    task automatic compare_all();
        ent_t e;
        e = (mq.size() > 0) ? mq[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
        chk("count", 32'(count), 32'(mq.size()));
        chk("out_pc", out_pc, e.pc);
        chk("out_opcode", 32'(out_opcode), 32'(e.op));
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_rs1", 32'(out_rs1), 32'(e.rs1));
        chk("out_rs2", 32'(out_rs2), 32'(e.rs2));
        chk("out_func3", 32'(out_func3), 32'(e.f3));
        chk("out_imm", out_imm, e.imm);
        chk("out_LoadStore", 32'(out_LoadStore), 32'(e.ls));
        chk("out_ALUSrc", 32'(out_ALUSrc), 32'(e.src));
        chk("out_RegWrite", 32'(out_RegWrite), 32'(e.rw));
        chk("out_BMS", 32'(out_BMS), 32'(e.bms));
        chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        chk("out_ALUControl", 32'(out_ALUControl), 32'(e.alu));
    endtask

    always @(negedge clk) if (chk_en) compare_all();

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom();
        case ($urandom_range(0, 9))
            0, 1: begin
                w[6:0]   = 7'h33;
                w[31:25] = ($urandom_range(0, 2) == 0) ? 7'h20 : 7'h00;
                if ($urandom_range(0, 9) == 0) w[31:25] = 7'($urandom());
            end
            2, 3: begin
                w[6:0] = 7'h13;
                if (w[13:12] == 2'b01 && $urandom_range(0, 3) != 0)
                    w[31:25] = ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h00;
            end
            4: begin
                w[6:0] = 7'h03;
                if ($urandom_range(0, 3) != 0) w[14:12] = {1'b0, w[13], 1'b0};
            end
            5: begin
                w[6:0] = 7'h23;
                if ($urandom_range(0, 3) != 0) w[14:12] = {1'b0, w[13], 1'b0};
            end
            6: w[6:0] = 7'h37;
            7: w = 32'd0;
            8: w[11:7] = 5'd0;
            default: ;
        endcase
        return w;
    endfunction

    task automatic push_hold(input logic [31:0] w, input logic [31:0] pc);
        in_valid  = 1'b1;
        in_instr  = w;
        in_pc     = pc;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 1) @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        chk_en = 1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        push_hold(32'h002081B3, 32'h100);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_rs1", 32'(out_rs1), 32'd1);
        chk("add_rs2", 32'(out_rs2), 32'd2);
        chk("add_alu", 32'(out_ALUControl), 32'b0010);
        chk("add_rw", 32'(out_RegWrite), 32'd1);
        chk("add_ill", 32'(out_illegal), 32'd0);
        drain();
        push_hold(32'h402081B3, 32'h104);
        chk("sub_alu", 32'(out_ALUControl), 32'b0110);
        drain();
        push_hold(32'h40335293, 32'h108);
        chk("srai_imm", out_imm, 32'd3);
        chk("srai_alu", 32'(out_ALUControl), 32'b1011);
        chk("srai_src", 32'(out_ALUSrc), 32'd1);
        drain();
        push_hold(32'hFFC10203, 32'h10C);
        chk("lb_imm", out_imm, 32'hFFFFFFFC);
        chk("lb_bms", 32'(out_BMS), 32'd1);
        chk("lb_ls", 32'(out_LoadStore), 32'd1);
        drain();
        push_hold(32'h00712423, 32'h110);
        chk("sw_imm", out_imm, 32'd8);
        chk("sw_rw", 32'(out_RegWrite), 32'd0);
        chk("sw_bms", 32'(out_BMS), 32'd0);
        drain();
        push_hold(32'hFFFFFFFF, 32'h114);
        chk("bad_ill", 32'(out_illegal), 32'd1);
        chk("bad_rw", 32'(out_RegWrite), 32'd0);
        drain();
        push_hold(32'h00100013, 32'h118);
        chk("addi_x0_rw", 32'(out_RegWrite), 32'd0);
        chk("addi_x0_ill", 32'(out_illegal), 32'd0);
        drain();
        push_hold(32'h00000000, 32'h11C);
        chk("nop_count", 32'(count), 32'd0);
        chk("nop_valid", 32'(out_valid), 32'd0);

        // Fill past capacity, then pop alone and pop+push from the full state.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            in_instr = 32'h00000013 | (32'(i + 1) << 7);
            in_pc    = 32'h200 + 32'(4 * i);
            @(negedge clk);
        end
        chk("full_count", 32'(count), 32'(DEPTH));
        chk("full_ready", 32'(in_ready), 32'd0);
        chk("full_head_pc", out_pc, 32'h200);
        in_instr  = 32'h00A00093;
        in_pc     = 32'h300;
        out_ready = 1'b1;
        @(negedge clk);
        chk("pop_from_full", 32'(count), 32'(DEPTH - 1));
        @(negedge clk);
        chk("pop_push_count", 32'(count), 32'(DEPTH - 1));
        chk("pop_push_head", out_pc, 32'h208);
        drain();

        // Flush with a concurrent push, then reset with a concurrent push.
        for (int i = 0; i < 3; i++) push_hold(32'h00208033, 32'h400 + 32'(4 * i));
        chk("pre_flush_count", 32'(count), 32'd3);
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        push_hold(32'h00208033, 32'h500);
        in_valid = 1'b1;
        reset    = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_valid", 32'(out_valid), 32'd0);

        for (int c = 0; c < 4000; c++) begin
            int bias;
            bias      = ((c / 200) % 3);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_pc     = $urandom() & 32'hFFFFFFFC;
            out_ready = (bias == 0) ? ($urandom_range(0, 3) == 0)
                      : (bias == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 0);
            flush     = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
